// File: rtl/gain_pkg.sv
// Shared types and constants for the gain ramp Avalon-MM writer.
// Optional readback compare is enabled by GAIN_RAMP_READBACK_EN.
package gain_pkg;

    localparam int AVM_DW = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
        RD,
        RDLAT,
        FIN
    } state_t;

    function automatic logic [31:0] COEF_UNITY(input int wdt);
        return 32'(1) << (wdt / 2);
    endfunction

endpackage

// File: rtl/gain_ramp_avm_if.sv
// Avalon-MM master bundle used by the gain ramp writer.
// Read data arrives with a fixed latency of one cycle.
interface gain_ramp_avm_if;
    import gain_pkg::*;

    logic              avmWr;
    logic              avmRd;
    logic [AVM_DW-1:0] avmWrData;
    logic [AVM_DW-1:0] avmRdData;
    logic              avmWaitReq;

    modport master (
        output avmWr,
        output avmRd,
        output avmWrData,
        input  avmRdData,
        input  avmWaitReq
    );

    modport slave (
        input  avmWr,
        input  avmRd,
        input  avmWrData,
        output avmRdData,
        output avmWaitReq
    );

endinterface

// File: rtl/gain_ramp_step.sv
// Clamped step toward target; one extra bit catches wrap-around.
// step of zero means jump straight to target.
module gain_ramp_step #(
    parameter int COEF_WDT = 16
) (
    input  logic [COEF_WDT-1:0] i_cur,
    input  logic [COEF_WDT-1:0] i_tgt,
    input  logic [COEF_WDT-1:0] i_stp,
    output logic [COEF_WDT-1:0] o_nxt
);

    logic [COEF_WDT:0] w_sum;
    logic [COEF_WDT:0] w_dif;

    assign w_sum = {1'b0, i_cur} + {1'b0, i_stp};
    assign w_dif = {1'b0, i_cur} - {1'b0, i_stp};

    // pick the next coefficient, never passing the target
    always_comb begin
        o_nxt = i_tgt;
        if (i_stp != '0) begin
            if (i_cur < i_tgt) begin
                if (w_sum < {1'b0, i_tgt})
                    o_nxt = w_sum[COEF_WDT-1:0];
            end else if (i_cur > i_tgt) begin
                if (!w_dif[COEF_WDT] && (w_dif[COEF_WDT-1:0] > i_tgt))
                    o_nxt = w_dif[COEF_WDT-1:0];
            end
        end
    end

endmodule

// File: rtl/gain_ramp_avm.sv
// Ramps a gain coefficient toward a target via Avalon-MM writes.
// Define GAIN_RAMP_READBACK_EN to verify the final write by readback.
module gain_ramp_avm
    import gain_pkg::*;
#(
    parameter int COEF_WDT = 16,
    parameter int GAP_WDT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [COEF_WDT-1:0] target,
    input  logic [COEF_WDT-1:0] step,
    input  logic [GAP_WDT-1:0]  gap,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [COEF_WDT-1:0] coefCur,
    gain_ramp_avm_if.master     avm
);

    localparam logic [COEF_WDT-1:0] UNITY =
        COEF_WDT'(COEF_UNITY(COEF_WDT));

    state_t              r_state;
    state_t              w_nxt;
    logic [COEF_WDT-1:0] r_target;
    logic [COEF_WDT-1:0] r_step;
    logic [GAP_WDT-1:0]  r_gap;
    logic [GAP_WDT-1:0]  r_cnt;
    logic [COEF_WDT-1:0] r_coefCur;
    logic [COEF_WDT-1:0] r_wrData;
    logic                r_avmWr;
    logic                r_abortReq;
    logic                w_idle;
    logic                w_wrAcc;
    logic                w_last;
    logic                w_abort;
    logic [COEF_WDT-1:0] w_cur;
    logic [COEF_WDT-1:0] w_tgt;
    logic [COEF_WDT-1:0] w_stp;
    logic [COEF_WDT-1:0] w_stepNext;

    assign w_idle  = (r_state == IDLE);
    assign w_wrAcc = (r_state == WR) && !avm.avmWaitReq;
    assign w_last  = (r_wrData == r_target);
    assign w_abort = abort || r_abortReq;

    // a write in flight becomes current once it is accepted
    assign w_cur = (r_state == WR) ? r_wrData : r_coefCur;
    assign w_tgt = w_idle ? target : r_target;
    assign w_stp = w_idle ? step : r_step;

    gain_ramp_step #(
        .COEF_WDT (COEF_WDT)
    ) u_step (
        .i_cur (w_cur),
        .i_tgt (w_tgt),
        .i_stp (w_stp),
        .o_nxt (w_stepNext)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_nxt;
    end

    // next-state decode
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start)
                    w_nxt = WR;
            end
            WR: begin
                if (!avm.avmWaitReq) begin
                    if (w_abort)
                        w_nxt = FIN;
                    else if (w_last)
`ifdef GAIN_RAMP_READBACK_EN
                        w_nxt = RD;
`else
                        w_nxt = FIN;
`endif
                    else if (r_gap == '0)
                        w_nxt = WR;
                    else
                        w_nxt = GAP;
                end
            end
            GAP: begin
                if (w_abort)
                    w_nxt = FIN;
                else if (r_cnt <= GAP_WDT'(1))
                    w_nxt = WR;
            end
`ifdef GAIN_RAMP_READBACK_EN
            RD: begin
                if (!avm.avmWaitReq)
                    w_nxt = w_abort ? FIN : RDLAT;
            end
            RDLAT: begin
                w_nxt = FIN;
            end
`endif
            FIN: begin
                w_nxt = IDLE;
            end
            default: begin
                w_nxt = IDLE;
            end
        endcase
    end

    // datapath: latched request, write data, gap counter, coefficient
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target   <= '0;
            r_step     <= '0;
            r_gap      <= '0;
            r_cnt      <= '0;
            r_coefCur  <= UNITY;
            r_wrData   <= '0;
            r_avmWr    <= 1'b0;
            r_abortReq <= 1'b0;
        end else begin
            r_avmWr <= (w_nxt == WR);
            if (w_idle && start) begin
                r_target <= target;
                r_step   <= step;
                r_gap    <= gap;
            end
            if (w_idle || r_state == FIN)
                r_abortReq <= 1'b0;
            else if (abort)
                r_abortReq <= 1'b1;
            if (w_nxt == WR && (r_state != WR || w_wrAcc))
                r_wrData <= w_stepNext;
            if (w_wrAcc) begin
                r_coefCur <= r_wrData;
                r_cnt     <= r_gap;
            end else if (r_state == GAP) begin
                r_cnt <= r_cnt - GAP_WDT'(1);
            end
        end
    end

`ifdef GAIN_RAMP_READBACK_EN
    logic r_avmRd;
    logic r_error;

    // read strobe and sticky compare result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_avmRd <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_avmRd <= (w_nxt == RD);
            if (w_idle && start)
                r_error <= 1'b0;
            else if (r_state == RDLAT &&
                     avm.avmRdData != AVM_DW'(r_target))
                r_error <= 1'b1;
        end
    end

    assign avm.avmRd = r_avmRd;
    assign error     = r_error;
`else
    logic w_unused;

    assign w_unused  = ^avm.avmRdData;
    assign avm.avmRd = 1'b0;
    assign error     = 1'b0;
`endif

    assign avm.avmWr     = r_avmWr;
    assign avm.avmWrData = AVM_DW'(r_wrData);
    assign coefCur       = r_coefCur;
    assign busy          = !w_idle;
    assign done          = (r_state == FIN);

endmodule
